fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have exactly one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the value driven on instr_o for a bubble.
REQ-004 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port stall_i, input, 1 bit: downstream hold; the IF/EX register keeps its contents.
REQ-007 Port br_taken_i, input, 1 bit: redirect request from the execute stage.
REQ-008 Port br_target_i, input, 32 bits: redirect address, valid when br_taken_i=1.
REQ-009 Port imem_req_o, output, 1 bit: one-cycle instruction-memory request pulse.
REQ-010 Port imem_addr_o, output, 32 bits: request address, valid when imem_req_o=1.
REQ-011 Port imem_rvalid_i, input, 1 bit: response strobe, at least 1 cycle after imem_req_o.
REQ-012 Port imem_rdata_i, input, 32 bits: instruction word, valid when imem_rvalid_i=1.
REQ-013 Port pc_o, output, 32 bits: IF/EX register PC.
REQ-014 Port instr_o, output, 32 bits: IF/EX register instruction.
REQ-015 Port valid_o, output, 1 bit: IF/EX register holds a real instruction.

Function
REQ-016 The FSM SHALL have the states ISSUE, WAIT and HOLD, plus a 1-bit kill flag, a 32-bit fetch_pc and a 32-bit skid buffer (skid_pc, skid_instr).
REQ-017 ISSUE SHALL drive imem_req_o=1 and imem_addr_o=fetch_pc for one cycle, then go to WAIT; imem_req_o SHALL be 0 in all other states.
REQ-018 In WAIT, with imem_rvalid_i=1, kill=0 and stall_i=0: load the IF/EX register with pc_o=fetch_pc, instr_o=imem_rdata_i and valid_o=1, add 4 to fetch_pc (mod 2^32), and go to ISSUE.
REQ-019 In WAIT, with imem_rvalid_i=1, kill=0 and stall_i=1: capture fetch_pc and imem_rdata_i in the skid buffer, add 4 to fetch_pc, and go to HOLD.
REQ-020 In HOLD, with stall_i=0: move the skid buffer into the IF/EX register with valid_o=1, then go to ISSUE.
REQ-021 In WAIT, with imem_rvalid_i=1 and kill=1: discard the response, clear kill, and go to ISSUE; fetch_pc is already the redirect target.
REQ-022 In any cycle with stall_i=0 and no instruction loaded, the IF/EX register SHALL become a bubble (valid_o=0, instr_o=NOP_INSTR; pc_o unchanged).
REQ-023 With stall_i=1 and no redirect, pc_o, instr_o and valid_o SHALL hold.
REQ-024 br_taken_i=1 SHALL override stall_i and every state; the next cycle SHALL have valid_o=0, instr_o=NOP_INSTR and fetch_pc=br_target_i.
REQ-025 Redirect in ISSUE (the request still goes out that cycle) SHALL set kill=1 and go to WAIT.
REQ-026 Redirect in WAIT with imem_rvalid_i=0 SHALL set kill=1 and stay in WAIT.
REQ-027 Redirect in WAIT with imem_rvalid_i=1 SHALL drop the response and go to ISSUE with kill=0.
REQ-028 Redirect in HOLD SHALL discard the skid buffer and go to ISSUE.
REQ-029 imem_rvalid_i in ISSUE or HOLD SHALL be ignored; at most one request is outstanding.
REQ-030 Best-case throughput SHALL be one instruction every 2 cycles (1-cycle memory).

Reset
REQ-031 While rst=1 the block SHALL force: state=ISSUE, fetch_pc=RESET_PC, kill=0, skid cleared, pc_o=0, instr_o=NOP_INSTR, valid_o=0, and imem_req_o=0.
REQ-032 The first cycle after rst falls SHALL issue a request at RESET_PC.
REQ-033 A reset asserted mid-request SHALL abandon the request, and a late imem_rvalid_i SHALL be ignored per REQ-029.

Verification
REQ-034 Reset release with 1-cycle memory returning 0x00100093, 0x00200113: imem_addr_o is 0x0, 0x4; pc_o/instr_o become 0x0/0x00100093, then 0x4/0x00200113, with valid_o=1.
REQ-035 stall_i=1 while the response for 0x8 arrives: the state goes to HOLD, imem_req_o=0, outputs hold; stall_i=0 loads pc_o=0x8, then a request for 0xC is issued.
REQ-036 br_taken_i=1 with target 0x40 in WAIT and the response 2 cycles later: the response is dropped, valid_o=0, and the next imem_addr_o is 0x40.
REQ-037 br_taken_i=1 and stall_i=1 in HOLD: the skid buffer is dropped, valid_o=0 and instr_o=0x00000013 next cycle, and the next request is at the target.
REQ-038 rst=1 pulsed for 1 cycle during WAIT: the stale imem_rvalid_i is ignored and the next request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a skid buffer for
// responses that arrive under stall, and redirect handling via a kill flag.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q;
    logic        kill_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] fetch_pc_d;

    assign fetch_pc_d = fetch_pc_q + 32'd4;

    // Gated by rst so no request leaks out while the state is forced to ISSUE.
    assign imem_req_o  = (state_q == S_ISSUE) && !rst;
    assign imem_addr_o = fetch_pc_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ISSUE;
            kill_q       <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            pc_q         <= '0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else if (br_taken_i) begin
            fetch_pc_q   <= br_target_i;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            unique case (state_q)
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    kill_q  <= 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= S_ISSUE;
                        kill_q  <= 1'b0;
                    end else begin
                        kill_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ISSUE;
                    kill_q  <= 1'b0;
                end
            endcase
        end else begin
            // Bubble unless a branch below loads a real instruction.
            if (!stall_i) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end
            unique case (state_q)
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_ISSUE;
                        end else if (!stall_i) begin
                            pc_q       <= fetch_pc_q;
                            instr_q    <= imem_rdata_i;
                            valid_q    <= 1'b1;
                            fetch_pc_q <= fetch_pc_d;
                            state_q    <= S_ISSUE;
                        end else begin
                            skid_pc_q    <= fetch_pc_q;
                            skid_instr_q <= imem_rdata_i;
                            fetch_pc_q   <= fetch_pc_d;
                            state_q      <= S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!stall_i) begin
                        pc_q    <= skid_pc_q;
                        instr_q <= skid_instr_q;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/skid, redirects,
// address wraparound and mid-request reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .valid_o      (valid_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br,
                         input logic [31:0] tgt, input logic rv,
                         input logic [31:0] rd);
        stall_i       = st;
        br_taken_i    = br;
        br_target_i   = tgt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #1;
    endtask

    task automatic chk_ifex(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic v);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_instr"}, instr_o, ins);
        chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    endtask

    task automatic chk_req(input string tag, input logic r,
                           input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, r});
        if (r) chk({tag, "_addr"}, imem_addr_o, a);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk_ifex("reset", 32'h0, NOP, 0);
        chk_req("reset", 0, 0);

        // Sequential fetch with 1-cycle memory
        rst = 1'b0;
        #1;
        chk_req("iss0", 1, 32'h0);
        tick();
        drive(0, 0, 0, 1, 32'h0010_0093);
        chk_req("wait0", 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("ld0", 32'h0, 32'h0010_0093, 1);
        chk_req("iss4", 1, 32'h4);
        tick();
        chk_ifex("bub0", 32'h0, NOP, 0);
        drive(0, 0, 0, 1, 32'h0020_0113);
        tick();
        chk_ifex("ld4", 32'h4, 32'h0020_0113, 1);
        chk_req("iss8", 1, 32'h8);

        // Stall across the response for 0x8 -> HOLD
        drive(1, 0, 0, 0, 0);
        tick();
        chk_ifex("stw", 32'h4, 32'h0020_0113, 1);
        drive(1, 0, 0, 1, 32'h0030_0193);
        tick();
        chk_ifex("hold", 32'h4, 32'h0020_0113, 1);
        chk_req("hold", 0, 0);
        drive(1, 0, 0, 1, 32'hDEAD_BEEF);
        tick();
        chk_ifex("hold2", 32'h4, 32'h0020_0113, 1);
        chk_req("hold2", 0, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk_ifex("ld8", 32'h8, 32'h0030_0193, 1);
        chk_req("issC", 1, 32'hC);

        // Redirect in WAIT, response arrives two cycles later
        tick();
        chk_ifex("bub8", 32'h8, NOP, 0);
        drive(0, 1, 32'h40, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("brw", 32'h8, NOP, 0);
        chk_req("brw", 0, 0);
        tick();
        drive(0, 0, 0, 1, 32'h00C0_0213);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("drop", 32'h8, NOP, 0);
        chk_req("iss40", 1, 32'h40);
        tick();
        drive(0, 0, 0, 1, 32'h0050_0293);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("ld40", 32'h40, 32'h0050_0293, 1);
        chk_req("iss44", 1, 32'h44);

        // Redirect with stall in HOLD drops the skid buffer
        drive(1, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 32'h0060_0313);
        tick();
        chk_ifex("hold44", 32'h40, 32'h0050_0293, 1);
        drive(1, 1, 32'h80, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("brh", 32'h40, NOP, 0);
        chk_req("iss80", 1, 32'h80);
        tick();
        drive(0, 0, 0, 1, 32'h0070_0393);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("ld80", 32'h80, 32'h0070_0393, 1);

        // Redirect in ISSUE: request still goes out, response killed
        drive(0, 1, 32'h100, 0, 0);
        chk_req("briss", 1, 32'h84);
        tick();
        drive(0, 0, 0, 1, 32'hBAD0_0001);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("kill", 32'h80, NOP, 0);
        chk_req("iss100", 1, 32'h100);

        // Address wraparound at 2^32
        tick();
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        tick();
        drive(0, 0, 0, 1, 32'hBAD0_0002);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_req("issFC", 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 1, 32'h0080_0413);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("ldFC", 32'hFFFF_FFFC, 32'h0080_0413, 1);
        chk_req("wrap", 1, 32'h0);

        // Reset pulse during WAIT; stale response ignored
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'hBAD0_0003);
        chk_ifex("rstw", 32'h0, NOP, 0);
        chk_req("rstiss", 1, 32'h0);
        tick();
        chk_ifex("stale", 32'h0, NOP, 0);
        drive(0, 0, 0, 1, 32'h0010_0093);
        tick();
        drive(0, 0, 0, 0, 0);
        chk_ifex("rld0", 32'h0, 32'h0010_0093, 1);
        chk_req("riss4", 1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
